// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a req/ready/rvalid handshake
// with a fixed access latency. Flags misaligned and out-of-range accesses and
// drives a combinational stall for the CPU pipe registers.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [2**ADDR_W];

    logic              accept;
    logic              do_acc;
    logic              acc_err;
    logic [ADDR_W-1:0] idx;

    // Checks run on the captured request, so they are stable for the whole access.
    assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
    assign idx     = addr_q[ADDR_W+1:2];

    assign ready_o  = (state_q == IDLE) || (state_q == RESP);
    assign accept   = req_i && ready_o;
    assign stall_o  = (state_q == WAIT) || (accept && (LATENCY != 0));
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // Next-state, request capture and response generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = 32'd0;
        do_acc   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Access happens on the edge that enters RESP.
                    do_acc   = 1'b1;
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    err_d    = acc_err;
                    if (!we_q && !acc_err) rdata_d = mem[idx];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset drops any pending access.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Byte-masked RAM write; contents survive reset, but a reset edge blocks the write.
    always_ff @(posedge clk_i) begin
        if (rst_i && do_acc && we_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        ready [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        stall [2];

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .be_i(be[0]), .ready_o(ready[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]), .stall_o(stall[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .be_i(be[1]), .ready_o(ready[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]), .stall_o(stall[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request from just after an edge; returns at the negedge after the accept edge.
    task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] er, input bit ee, input bit track);
        exp_t e;
        @(posedge clk); #1;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        if (track) begin
            e.rdata = er; e.err = ee;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("accept ready", ready[k], 1);
        chk("accept stall", stall[k], 1);
        @(posedge clk); #1;
        req[k] = 1'b0;
        @(negedge clk);
        chk("post-accept stall", stall[k], 1);
    endtask

    // Count edges since the accept edge until rvalid, then score against the queue.
    task automatic wait_resp(input int k, input int exp_lat, input string tag);
        int   n = 0;
        bit   got = 1'b0;
        exp_t e;
        while (n < 20 && !got) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (rvalid[k]) got = 1'b1;
            else chk({tag, " wait stall"}, stall[k], 1);
        end
        chk({tag, " rvalid seen"}, got, 1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " latency"}, n, exp_lat);
            chk({tag, " rdata"}, rdata[k], e.rdata);
            chk({tag, " err"}, err[k], e.err);
            chk({tag, " resp stall"}, stall[k], req[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; we[k] = 0; addr[k] = 0; wdata[k] = 0; be[k] = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst ready", ready[0], 1);
        chk("rst rvalid", rvalid[0], 0);
        chk("rst err", err[0], 0);
        chk("rst rdata", rdata[0], 0);
        chk("rst stall", stall[0], 0);
        chk("rst ready L1", ready[1], 1);

        // Full-word store and readback
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1);
        wait_resp(0, 2, "st10");
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1);
        wait_resp(0, 2, "ld10");

        // Byte-enable merge
        issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1);
        wait_resp(0, 2, "st20");
        issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 1);
        wait_resp(0, 2, "st20be");
        issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 1);
        wait_resp(0, 2, "ld20");

        // No-op store still responds and leaves data alone
        issue(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 1);
        wait_resp(0, 2, "st20nop");
        issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 1);
        wait_resp(0, 2, "ld20b");

        // Back-to-back store then load of the same word accepted in RESP
        @(posedge clk); #1;
        req[0] = 1; we[0] = 1; addr[0] = 32'h30; wdata[0] = 32'h5; be[0] = 4'hF;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        @(posedge clk); #1;
        we[0] = 0; wdata[0] = 32'h0;
        sb.push_back('{rdata: 32'h5, err: 1'b0});
        wait_resp(0, 2, "b2b st");
        @(posedge clk); #1 req[0] = 0;
        wait_resp(0, 2, "b2b ld");

        // Error cases
        issue(0, 0, 32'h12, 32'h0, 4'h0, 32'h0, 1, 1);
        wait_resp(0, 2, "ld misalign");
        issue(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1);
        wait_resp(0, 2, "st0");
        issue(0, 1, 32'h1000, 32'h99999999, 4'hF, 32'h0, 1, 1);
        wait_resp(0, 2, "st range");
        issue(0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1);
        wait_resp(0, 2, "ld0");

        // Reset during WAIT drops the pending store
        issue(0, 1, 32'h40, 32'h12345678, 4'hF, 32'h0, 0, 1);
        wait_resp(0, 2, "st40");
        issue(0, 1, 32'h40, 32'h77, 4'hF, 32'h0, 0, 0);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst rvalid", rvalid[0], 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst rvalid", rvalid[0], 0);
        end
        chk("postrst ready", ready[0], 1);
        issue(0, 0, 32'h40, 32'h0, 4'h0, 32'h12345678, 0, 1);
        wait_resp(0, 2, "ld40");

        // LATENCY=1 instance
        issue(1, 1, 32'h8, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 1);
        wait_resp(1, 1, "L1 st8");
        issue(1, 0, 32'h8, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 1);
        wait_resp(1, 1, "L1 ld8");
        issue(1, 0, 32'h9, 32'h0, 4'h0, 32'h0, 1, 1);
        wait_resp(1, 1, "L1 misalign");

        @(posedge clk);
        @(negedge clk);
        chk("idle rvalid", rvalid[0], 0);
        chk("idle rdata", rdata[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
